// File: rtl/pps_phase_ctrl_if.sv
// pps_phase_ctrl_if: 1PPS inputs and phase-compensation/status outputs
// shared between the phase controller and the divider/system side.
interface pps_phase_ctrl_if;
    logic        _1PPS_GPS;
    logic        _1PPS_Local;
    logic        Phase_Compensate_Type;
    logic [11:0] Phase_Compensate;
    logic [24:0] Phase_Err;
    logic        Err_Valid;
    logic        Locked;
    logic        Holdover;

    // System/divider side: drives the PPS inputs, observes the controller
    modport master (
        output _1PPS_GPS,
        output _1PPS_Local,
        input  Phase_Compensate_Type,
        input  Phase_Compensate,
        input  Phase_Err,
        input  Err_Valid,
        input  Locked,
        input  Holdover
    );

    // Controller side
    modport slave (
        input  _1PPS_GPS,
        input  _1PPS_Local,
        output Phase_Compensate_Type,
        output Phase_Compensate,
        output Phase_Err,
        output Err_Valid,
        output Locked,
        output Holdover
    );
endinterface

// File: rtl/pps_phase_ctrl.sv
// pps_phase_ctrl: measures local-vs-GPS 1PPS offset once per local second and
// drives the divider's compensation inputs for the following period; reports
// lock and holdover status.
module pps_phase_ctrl #(
    parameter int PERIOD     = 10_000_000,
    parameter int CAL_OFFSET = 3,
    parameter int GAIN_SHIFT = 0,
    parameter int MAX_STEP   = 4095,
    parameter int DEADBAND   = 4,
    parameter int LOCK_CNT   = 8
) (
    input  logic            CLK_Sys,
    input  logic            CLK_Rst,
    pps_phase_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        WAIT_GPS = 2'd0,
        TRACK    = 2'd1,
        HOLDOVER = 2'd2
    } state_t;

    localparam int               RUN_W    = $clog2(LOCK_CNT + 1);
    localparam logic [24:0]      CNT_MAX  = {25{1'b1}};
    localparam logic [25:0]      TIMEOUT  = 26'(2 * PERIOD);
    localparam logic [25:0]      HALF     = 26'(PERIOD / 2);
    localparam logic [25:0]      PER      = 26'(PERIOD);
    localparam logic [RUN_W-1:0] RUN_FULL = RUN_W'(LOCK_CNT);

    state_t            state_r, state_nxt_s;
    logic              gps_meta_r, gps_sync_r, gps_prev_r, loc_prev_r;
    logic              gps_evt_s, loc_evt_s;
    logic [24:0]       cnt_r, cnt_nxt_s;
    logic              armed_r, armed_nxt_s;
    logic [RUN_W-1:0]  run_r, run_nxt_s;
    logic              comp_type_r, comp_type_nxt_s;
    logic [11:0]       comp_r, comp_nxt_s;
    logic [24:0]       err_r, err_nxt_s;
    logic              err_valid_r, err_valid_nxt_s;
    logic              locked_r, locked_nxt_s;
    logic              holdover_r, holdover_nxt_s;
    logic [25:0]       dadj_s, e_s, ae_s, shifted_s;
    logic              meas_type_s, in_band_s;
    logic [11:0]       mag_s;

    // GPS 2-FF synchronizer plus one-cycle history of both PPS inputs
    always_ff @(posedge CLK_Sys or negedge CLK_Rst) begin
        if (!CLK_Rst) begin
            gps_meta_r <= 1'b0;
            gps_sync_r <= 1'b0;
            gps_prev_r <= 1'b0;
            loc_prev_r <= 1'b0;
        end else begin
            gps_meta_r <= bus._1PPS_GPS;
            gps_sync_r <= gps_meta_r;
            gps_prev_r <= gps_sync_r;
            loc_prev_r <= bus._1PPS_Local;
        end
    end

    assign gps_evt_s = gps_sync_r & ~gps_prev_r;
    assign loc_evt_s = bus._1PPS_Local & ~loc_prev_r;

    // Phase counter: restarts on the GPS edge, otherwise counts up and saturates
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (gps_evt_s) begin
            cnt_nxt_s = 25'd0;
        end else if (cnt_r == CNT_MAX) begin
            cnt_nxt_s = CNT_MAX;
        end else begin
            cnt_nxt_s = cnt_r + 25'd1;
        end
    end

    // Error/magnitude from the updated count, so a coincident GPS edge gives D = 0
    always_comb begin
        dadj_s      = {1'b0, cnt_nxt_s} + 26'(CAL_OFFSET);
        e_s         = dadj_s;
        meas_type_s = 1'b1;
        if (dadj_s <= HALF) begin
            e_s         = dadj_s;
            meas_type_s = 1'b1;
        end else begin
            e_s         = dadj_s - PER;
            meas_type_s = 1'b0;
        end
        ae_s      = e_s[25] ? (26'd0 - e_s) : e_s;
        shifted_s = ae_s >> GAIN_SHIFT;
        in_band_s = 1'b0;
        mag_s     = 12'd0;
        if (ae_s <= 26'(DEADBAND)) begin
            in_band_s = 1'b1;
            mag_s     = 12'd0;
        end else if (shifted_s > 26'(MAX_STEP)) begin
            in_band_s = 1'b0;
            mag_s     = 12'(MAX_STEP);
        end else begin
            in_band_s = 1'b0;
            mag_s     = shifted_s[11:0];
        end
    end

    // Next state, arming, lock run and output values
    always_comb begin
        state_nxt_s     = state_r;
        armed_nxt_s     = armed_r;
        run_nxt_s       = run_r;
        comp_type_nxt_s = comp_type_r;
        comp_nxt_s      = comp_r;
        err_nxt_s       = err_r;
        err_valid_nxt_s = 1'b0;
        locked_nxt_s    = locked_r;
        holdover_nxt_s  = holdover_r;

        if (gps_evt_s && !loc_evt_s) begin
            armed_nxt_s = 1'b1;
        end else if (loc_evt_s) begin
            armed_nxt_s = 1'b0;
        end else begin
            armed_nxt_s = armed_r;
        end

        case (state_r)
            WAIT_GPS: begin
                if (gps_evt_s) begin
                    state_nxt_s = TRACK;
                end else begin
                    state_nxt_s = WAIT_GPS;
                end
            end
            TRACK: begin
                if (!gps_evt_s && ({1'b0, cnt_nxt_s} >= TIMEOUT)) begin
                    state_nxt_s     = HOLDOVER;
                    holdover_nxt_s  = 1'b1;
                    locked_nxt_s    = 1'b0;
                    run_nxt_s       = '0;
                    comp_nxt_s      = 12'd0;
                    comp_type_nxt_s = 1'b0;
                end else if (loc_evt_s && (armed_r || gps_evt_s)) begin
                    comp_type_nxt_s = meas_type_s;
                    comp_nxt_s      = mag_s;
                    err_nxt_s       = e_s[24:0];
                    err_valid_nxt_s = 1'b1;
                    if (in_band_s) begin
                        run_nxt_s    = (run_r == RUN_FULL) ? run_r : run_r + 1'b1;
                        locked_nxt_s = (run_nxt_s == RUN_FULL);
                    end else begin
                        run_nxt_s    = '0;
                        locked_nxt_s = 1'b0;
                    end
                end else if (loc_evt_s) begin
                    // Unpaired local edge: leave the next period uncorrected
                    comp_nxt_s = 12'd0;
                end else begin
                    state_nxt_s = TRACK;
                end
            end
            HOLDOVER: begin
                if (gps_evt_s) begin
                    state_nxt_s    = TRACK;
                    holdover_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = HOLDOVER;
                end
            end
            default: begin
                state_nxt_s = WAIT_GPS;
            end
        endcase
    end

    // State register
    always_ff @(posedge CLK_Sys or negedge CLK_Rst) begin
        if (!CLK_Rst) begin
            state_r <= WAIT_GPS;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Counter, arming, lock run and registered outputs
    always_ff @(posedge CLK_Sys or negedge CLK_Rst) begin
        if (!CLK_Rst) begin
            cnt_r       <= 25'd0;
            armed_r     <= 1'b0;
            run_r       <= '0;
            comp_type_r <= 1'b0;
            comp_r      <= 12'd0;
            err_r       <= 25'd0;
            err_valid_r <= 1'b0;
            locked_r    <= 1'b0;
            holdover_r  <= 1'b0;
        end else begin
            cnt_r       <= cnt_nxt_s;
            armed_r     <= armed_nxt_s;
            run_r       <= run_nxt_s;
            comp_type_r <= comp_type_nxt_s;
            comp_r      <= comp_nxt_s;
            err_r       <= err_nxt_s;
            err_valid_r <= err_valid_nxt_s;
            locked_r    <= locked_nxt_s;
            holdover_r  <= holdover_nxt_s;
        end
    end

    assign bus.Phase_Compensate_Type = comp_type_r;
    assign bus.Phase_Compensate      = comp_r;
    assign bus.Phase_Err             = err_r;
    assign bus.Err_Valid             = err_valid_r;
    assign bus.Locked                = locked_r;
    assign bus.Holdover              = holdover_r;
endmodule

// File: doc/pps_phase_ctrl.md
# pps_phase_ctrl

Closed-loop phase controller for the 10 MHz 1PPS divider. It measures the offset between the GPS 1PPS and the local 1PPS on every local second. From that offset it drives the divider's `Phase_Compensate_Type` / `Phase_Compensate` inputs for the following period, which steers the local 1PPS onto the GPS edge. It also reports lock and holdover status to the system.

## Interface
Parameters:
- `PERIOD`, 10_000_000: divider cycles per second.
- `CAL_OFFSET`, 3: fixed GPS synchronizer/edge-detect latency, added to every raw measurement.
- `GAIN_SHIFT`, 0: loop gain; the compensation magnitude is right-shifted by this amount.
- `MAX_STEP`, 4095: clamp on the compensation magnitude. Must be ≤ 4095.
- `DEADBAND`, 4: |error| at or below this gives zero compensation and counts toward lock.
- `LOCK_CNT`, 8: consecutive in-deadband measurements needed to assert lock.

Ports:
- `CLK_Sys` in 1: 10 MHz system clock.
- `CLK_Rst` in 1: reset, asynchronous, active-low.
- `_1PPS_GPS` in 1: GPS 1PPS, asynchronous to `CLK_Sys`.
- `_1PPS_Local` in 1: local 1PPS from the divider, synchronous to `CLK_Sys`.
- `Phase_Compensate_Type` out 1: 1 shortens the period (local lags); 0 lengthens it.
- `Phase_Compensate` out 12: compensation magnitude in clock cycles.
- `Phase_Err` out 25: signed error in cycles; positive means local lags GPS.
- `Err_Valid` out 1: one-cycle strobe when `Phase_Err` updates.
- `Locked` out 1: loop locked.
- `Holdover` out 1: GPS absent.

## Operation
- GPS input: 2-FF synchronizer, then a rising-edge detect giving `gps_evt`. Local edge: `loc_evt` = `_1PPS_Local & ~_1PPS_Local_d`.
- Phase counter: 25-bit.
  - Cleared to 0 on `gps_evt`; otherwise increments.
  - Saturates at all-ones.
- `armed` flag: set by `gps_evt`, cleared by `loc_evt`.
- States:
  - WAIT_GPS (reset state): outputs stay at reset values. The first `gps_evt` moves to TRACK.
  - TRACK: normal measurement; described below.
  - HOLDOVER: compensation held at 0. The next `gps_evt` moves to TRACK.
- TRACK, `loc_evt` with `armed`=1:
  - D = counter value; Dadj = D + CAL_OFFSET.
  - If Dadj ≤ PERIOD/2: E = +Dadj, Type = 1.
  - Otherwise: E = −(PERIOD − Dadj), Type = 0.
  - Mag = |E| >> GAIN_SHIFT, clamped to MAX_STEP.
  - If |E| ≤ DEADBAND: Mag = 0, and the lock run counter increments (saturating at LOCK_CNT). Otherwise the run counter is cleared and `Locked` = 0.
  - `Locked` = 1 when the run counter reaches LOCK_CNT.
- TRACK, `loc_evt` with `armed`=0: no measurement, no `Err_Valid`, `Phase_Compensate` = 0 for that period. `Locked` and the run counter are unchanged.
- `gps_evt` and `loc_evt` in the same cycle: D = 0 (measurement pairs with this GPS edge). The counter restarts at 0 and `armed` ends at 0.
- Timeout: counter reaches 2·PERIOD with no `gps_evt` (WAIT_GPS excluded).
  - Moves to HOLDOVER: `Holdover` = 1, `Locked` = 0, run counter cleared, compensation outputs 0.
  - `gps_evt` in HOLDOVER returns to TRACK and clears `Holdover` on the next cycle.
- Compensation outputs are held from one `loc_evt` to the next. The divider applies each value to exactly the period that starts at the measured edge.

## Timing
- Reset: all outputs 0. State WAIT_GPS; counter, `armed` and run counter cleared.
- Reset mid-operation: returns immediately to this reset condition.
- `gps_evt` asserts 3 cycles after a GPS rising edge (1 cycle uncertainty); this is the latency CAL_OFFSET covers.
- `loc_evt` asserts in the first cycle `_1PPS_Local` is high.
- Outputs are registered:
  - `Phase_Compensate`, `Phase_Compensate_Type`, `Phase_Err`, `Locked` update at `loc_evt` + 1 cycle.
  - `Err_Valid` is high for that one cycle only.
  - The divider counter is ≤ 2 when the outputs change.
- `Holdover` asserts the cycle after the timeout count is reached.

## Test plan
- Reset: assert `CLK_Rst`=0 mid-TRACK → all outputs 0 next edge. Release, then toggle `_1PPS_Local` with no GPS → no `Err_Valid`, compensation 0.
- Lag (PERIOD=1000): `gps_evt`, `loc_evt` 100 cycles later → `Phase_Err`=+103, Type=1, `Phase_Compensate`=103, one `Err_Valid` pulse.
- Lead (PERIOD=1000): D=900 → `Phase_Err`=−97, Type=0, `Phase_Compensate`=97.
- Clamp (PERIOD=20000): D=6000 → `Phase_Err`=+6003, `Phase_Compensate`=4095. Repeat with GAIN_SHIFT=2, D=400 → 100.
- Lock (DEADBAND=4, LOCK_CNT=3): three seconds with D=0 → `Phase_Compensate`=0 each time, `Locked`=1 after the third. Fourth second with D=20 → `Locked`=0, compensation 23. Simultaneous `gps_evt`/`loc_evt` → E=+3.
- Holdover (PERIOD=1000): stop GPS → `Holdover`=1 at 2000 cycles after the last `gps_evt`, `Locked`=0, compensation 0. Restore GPS → `Holdover`=0, measurements resume.
